bmem_responder: RTL and testbench



---
 rtl/bmem_responder.sv | 185 ++++++++++++++++++
 tb/tb_bmem_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_responder.sv
// Line-organised burst memory responder: 4-beat line reads after a fixed latency, 4-beat line writebacks.
// Optional BMEM_RESPONDER_STALL_EN adds LFSR-driven backpressure on bmem_ready.
module bmem_responder #(
    parameter int DEPTH_LINES  = 256,
    parameter int READ_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic        bmem_rvalid,
    output logic [63:0] bmem_rdata,
    output logic        proto_err
);

    localparam int IW = $clog2(DEPTH_LINES);
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(READ_LATENCY - 1);
    localparam logic [LW-1:0] LAT_ONE  = LW'(1);
    localparam logic [LW-1:0] LAT_ZERO = {LW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RLAT   = 2'd1,
        ST_RBURST = 2'd2,
        ST_WBURST = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [LW-1:0]   lat_r, lat_s;
    logic [1:0]      beat_r, beat_s;
    logic [IW-1:0]   line_r, line_s;
    logic [IW-1:0]   addr_idx_s;
    logic            err_s;
    logic            wr_en_s;
    logic [1:0]      wr_word_s;
    logic            gate_s;
    logic            ready_s;
    logic [IW+1:0]   wr_idx_s;
    logic [IW+1:0]   rd_idx_s;
    logic            addr_unused_s;

    logic [63:0] mem_r [DEPTH_LINES*4];

    assign addr_idx_s    = bmem_addr[5 +: IW];
    assign addr_unused_s = ^{bmem_addr[31:5+IW], bmem_addr[4:0]};
    assign wr_idx_s      = {addr_idx_s, wr_word_s};
    assign rd_idx_s      = {line_s, beat_s};

`ifdef BMEM_RESPONDER_STALL_EN
    logic [7:0] lfsr_r;
    logic [7:0] lfsr_s;

    // Fibonacci LFSR, taps 8,6,5,4; ready for the next cycle uses the advanced value.
    always_comb begin
        lfsr_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        gate_s = lfsr_s[0];
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= lfsr_s;
        end
    end
`else
    assign gate_s = 1'b1;
`endif

    // Next-state, beat/latency counters, write strobe and sticky error.
    always_comb begin
        state_s   = state_r;
        lat_s     = lat_r;
        beat_s    = beat_r;
        line_s    = line_r;
        err_s     = proto_err;
        wr_en_s   = 1'b0;
        wr_word_s = 2'd0;
        case (state_r)
            ST_IDLE: begin
                if (bmem_ready && bmem_write) begin
                    wr_en_s   = 1'b1;
                    wr_word_s = 2'd0;
                    beat_s    = 2'd1;
                    state_s   = ST_WBURST;
                    if (bmem_read) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = proto_err;
                    end
                end else if (bmem_ready && bmem_read) begin
                    line_s = addr_idx_s;
                    beat_s = 2'd0;
                    lat_s  = LAT_INIT;
                    if (LAT_INIT == LAT_ZERO) begin
                        state_s = ST_RBURST;
                    end else begin
                        state_s = ST_RLAT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RLAT: begin
                // Counter reaching zero on this edge makes the first beat land READ_LATENCY cycles after acceptance.
                if (lat_r == LAT_ONE || lat_r == LAT_ZERO) begin
                    state_s = ST_RBURST;
                    lat_s   = LAT_ZERO;
                    beat_s  = 2'd0;
                end else begin
                    lat_s = lat_r - LAT_ONE;
                end
            end
            ST_RBURST: begin
                beat_s = beat_r + 2'd1;
                if (beat_r == 2'd3) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RBURST;
                end
            end
            ST_WBURST: begin
                if (bmem_read) begin
                    err_s = 1'b1;
                end else begin
                    err_s = proto_err;
                end
                if (bmem_ready && bmem_write) begin
                    wr_en_s   = 1'b1;
                    wr_word_s = beat_r;
                    beat_s    = beat_r + 2'd1;
                    if (beat_r == 2'd3) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_WBURST;
                    end
                end else begin
                    state_s = ST_WBURST;
                end
            end
            default: begin
                state_s = ST_IDLE;
                beat_s  = 2'd0;
                lat_s   = LAT_ZERO;
            end
        endcase
        ready_s = ((state_s == ST_IDLE) || (state_s == ST_WBURST)) && gate_s;
    end

    // FSM state and registered outputs, computed one cycle ahead from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            lat_r       <= LAT_ZERO;
            beat_r      <= 2'd0;
            line_r      <= {IW{1'b0}};
            proto_err   <= 1'b0;
            bmem_ready  <= 1'b1;
            bmem_rvalid <= 1'b0;
            bmem_rdata  <= 64'd0;
        end else begin
            state_r     <= state_s;
            lat_r       <= lat_s;
            beat_r      <= beat_s;
            line_r      <= line_s;
            proto_err   <= err_s;
            bmem_ready  <= ready_s;
            bmem_rvalid <= (state_s == ST_RBURST);
            bmem_rdata  <= (state_s == ST_RBURST) ? mem_r[rd_idx_s] : 64'd0;
        end
    end

    // Backing store; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= bmem_wdata;
        end
    end

endmodule

// File: tb/tb_bmem_responder.sv
// Self-checking bench for bmem_responder: directed protocol cases plus randomized write/read traffic
// checked against a word-array reference model and the read-timing rules.
module tb_bmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bmem_addr = 32'd0;
    logic        bmem_read = 1'b0;
    logic        bmem_write = 1'b0;
    logic [63:0] bmem_wdata = 64'd0;
    logic        bmem_ready;
    logic        bmem_rvalid;
    logic [63:0] bmem_rdata;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    logic [63:0] model [DEPTH][4];
    bit          written [DEPTH];
    int          wlines [$];

    bmem_responder #(.DEPTH_LINES(DEPTH), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bmem_addr(bmem_addr), .bmem_read(bmem_read),
        .bmem_write(bmem_write), .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
        .bmem_rvalid(bmem_rvalid), .bmem_rdata(bmem_rdata), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_of(logic [31:0] a);
        return int'((a / 32'd32) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] alias_addr(int line);
        logic [31:0] mask;
        mask = ~(32'(DEPTH - 1) << 5);
        return ($urandom & mask) | (32'(line) << 5);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (bmem_ready !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (bmem_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", bmem_ready, n);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] data);
        int line;
        line = line_of(addr);
        for (int k = 0; k < 4; k++) begin
            wait_ready();
            bmem_addr  = addr;
            bmem_write = 1'b1;
            bmem_wdata = data[64*k +: 64];
            step();
            model[line][k] = data[64*k +: 64];
`ifndef BMEM_RESPONDER_STALL_EN
            checks++;
            if (bmem_ready !== 1'b1) begin
                errors++;
                $display("FAIL wr_ready line=%0d beat=%0d: ready=%b required 1", line, k, bmem_ready);
            end
`endif
        end
        bmem_write = 1'b0;
        if (!written[line]) wlines.push_back(line);
        written[line] = 1'b1;
    endtask

    task automatic do_read(input logic [31:0] addr);
        int line;
        logic        exp_v;
        logic [63:0] exp_d;
        line = line_of(addr);
        wait_ready();
        bmem_addr = addr;
        bmem_read = 1'b1;
        step();
        bmem_read = 1'b0;
        for (int c = 1; c <= LAT + 4; c++) begin
            if (c > 1) step();
            exp_v = (c >= LAT) && (c <= LAT + 3);
            exp_d = exp_v ? model[line][c - LAT] : 64'd0;
            checks++;
            if (bmem_rvalid !== exp_v || bmem_rdata !== exp_d) begin
                errors++;
                $display("FAIL rd_beat addr=%h cyc=%0d: rvalid=%b rdata=%h required rvalid=%b rdata=%h",
                         addr, c, bmem_rvalid, bmem_rdata, exp_v, exp_d);
            end
            if (c <= LAT + 3) begin
                checks++;
                if (bmem_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_ready_low addr=%h cyc=%0d: ready=%b required 0", addr, c, bmem_ready);
                end
            end else begin
`ifndef BMEM_RESPONDER_STALL_EN
                checks++;
                if (bmem_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_ready_back addr=%h: ready=%b required 1", addr, bmem_ready);
                end
`endif
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (bmem_ready !== 1'b1 || bmem_rvalid !== 1'b0 || bmem_rdata !== 64'd0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rvalid=%b rdata=%h err=%b required 1 0 0 0",
                     bmem_ready, bmem_rvalid, bmem_rdata, proto_err);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_write(32'h0000_00A0, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        do_read(32'h0000_00A0);
        do_read(32'h0000_00BF);
        do_read(32'h0000_20A0);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err: proto_err=%b required 0", proto_err);
        end
    endtask

    task automatic test_write_hold();
        logic [63:0] d [4];
        for (int k = 0; k < 4; k++) d[k] = rnd64();
        wait_ready();
        bmem_addr  = 32'h0000_0120;
        bmem_write = 1'b1;
        bmem_wdata = d[0];
        step();
        bmem_write = 1'b0;
        model[9][0] = d[0];
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (proto_err !== 1'b0 || bmem_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle cyc=%0d: err=%b rvalid=%b required 0 0", i, proto_err, bmem_rvalid);
            end
`ifndef BMEM_RESPONDER_STALL_EN
            checks++;
            if (bmem_ready !== 1'b1) begin
                errors++;
                $display("FAIL hold_ready cyc=%0d: ready=%b required 1", i, bmem_ready);
            end
`endif
        end
        for (int k = 1; k < 4; k++) begin
            wait_ready();
            bmem_addr  = 32'h0000_0120;
            bmem_write = 1'b1;
            bmem_wdata = d[k];
            step();
            bmem_write = 1'b0;
            model[9][k] = d[k];
        end
        if (!written[9]) wlines.push_back(9);
        written[9] = 1'b1;
        do_read(32'h0000_0120);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_err: proto_err=%b required 0", proto_err);
        end
    endtask

    task automatic test_conflict();
        logic [63:0] d [4];
        for (int k = 0; k < 4; k++) d[k] = rnd64();
        wait_ready();
        bmem_addr  = 32'h0000_0180;
        bmem_read  = 1'b1;
        bmem_write = 1'b1;
        bmem_wdata = d[0];
        step();
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        model[12][0] = d[0];
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (proto_err !== 1'b1 || bmem_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL conflict cyc=%0d: err=%b rvalid=%b required 1 0", i, proto_err, bmem_rvalid);
            end
            step();
        end
        for (int k = 1; k < 4; k++) begin
            wait_ready();
            bmem_write = 1'b1;
            bmem_wdata = d[k];
            step();
            bmem_write = 1'b0;
            model[12][k] = d[k];
        end
        if (!written[12]) wlines.push_back(12);
        written[12] = 1'b1;
        do_read(32'h0000_0180);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL conflict_sticky: proto_err=%b required 1", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        wait_ready();
        bmem_addr = 32'h0000_00A0;
        bmem_read = 1'b1;
        step();
        bmem_read = 1'b0;
        repeat (LAT) step();
        checks++;
        if (bmem_rvalid !== 1'b1 || bmem_rdata !== model[5][1]) begin
            errors++;
            $display("FAIL midrst_beat1: rvalid=%b rdata=%h required 1 %h", bmem_rvalid, bmem_rdata, model[5][1]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bmem_rvalid !== 1'b0 || bmem_ready !== 1'b1 || proto_err !== 1'b0 || bmem_rdata !== 64'd0) begin
            errors++;
            $display("FAIL midrst_outputs: rvalid=%b ready=%b err=%b rdata=%h required 0 1 0 0",
                     bmem_rvalid, bmem_ready, proto_err, bmem_rdata);
        end
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (bmem_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_abandon cyc=%0d: rvalid=%b required 0", i, bmem_rvalid);
            end
        end
        do_read(32'h0000_00A0);
    endtask

    task automatic test_back_to_back();
        do_write(alias_addr(200), {rnd64(), rnd64(), rnd64(), rnd64()});
        do_write(alias_addr(201), {rnd64(), rnd64(), rnd64(), rnd64()});
        do_read(alias_addr(200));
        do_write(alias_addr(200), {rnd64(), rnd64(), rnd64(), rnd64()});
        do_read(alias_addr(200));
        do_read(alias_addr(201));
    endtask

    task automatic test_random();
        int line;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) != 0 || wlines.size() == 0) begin
                line = $urandom_range(0, DEPTH - 1);
                do_write(alias_addr(line), {rnd64(), rnd64(), rnd64(), rnd64()});
            end else begin
                line = wlines[$urandom_range(0, wlines.size() - 1)];
            end
            repeat ($urandom_range(0, 2)) step();
            do_read(alias_addr(line));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_write_hold();
        test_conflict();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
